// File: rtl/lsu_sram_master.sv
// Load-store unit master for an SRAM-like bus with req/addr_ok/data_ok handshake.
// One request is held until the address phase completes; response order is kept by an info FIFO.
module lsu_sram_master #(
    parameter int unsigned BUS_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned RAM_MASK_WIDTH  = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic                      lsu_we,
    input  logic [2:0]                lsu_funct3,
    input  logic [BUS_WIDTH-1:0]      lsu_addr,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      bus_err,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [1:0]                mem_size,
    output logic [BUS_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [RAM_MASK_WIDTH-1:0] mem_wem,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_addr_ok,
    input  logic                      mem_data_ok
);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic       bus;
        logic       we;
        logic [2:0] funct3;
        logic [1:0] lane;
    } entry_t;

    entry_t                    r_fifo [MAX_OUTSTANDING];
    logic [PtrW-1:0]           r_wr_ptr;
    logic [PtrW-1:0]           r_rd_ptr;
    logic [CntW-1:0]           r_count;
    logic                      r_hold_valid;
    entry_t                    r_hold;
    logic                      r_mem_we;
    logic [1:0]                r_mem_size;
    logic [BUS_WIDTH-1:0]      r_mem_addr;
    logic [DATA_WIDTH-1:0]     r_mem_wdata;
    logic [RAM_MASK_WIDTH-1:0] r_mem_wem;
    logic                      r_rsp_valid;
    logic [DATA_WIDTH-1:0]     r_rsp_rdata;
    logic                      r_rsp_err;
    logic                      r_bus_err;

    logic                      w_misalign;
    logic [1:0]                w_size;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic [RAM_MASK_WIDTH-1:0] w_wem;
    logic                      w_accept;
    logic                      w_bypass;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_stray;
    logic                      w_nonempty;
    entry_t                    w_head;
    entry_t                    w_push_entry;
    logic [DATA_WIDTH-1:0]     w_lane_data;
    logic [DATA_WIDTH-1:0]     w_load_ext;

    assign lsu_ready  = !r_hold_valid && (r_count < CntW'(MAX_OUTSTANDING));
    assign w_accept   = lsu_valid && lsu_ready;
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_fifo[r_rd_ptr];
    // Misaligned request with nothing ahead of it answers directly, one cycle after acceptance.
    assign w_bypass   = w_accept && w_misalign && !w_nonempty;
    assign w_push     = (w_accept && w_misalign && w_nonempty) || (r_hold_valid && mem_addr_ok);
    assign w_pop      = w_nonempty && (!w_head.bus || mem_data_ok);
    assign w_stray    = mem_data_ok && (!w_nonempty || !w_head.bus);

    always_comb begin
        w_misalign = 1'b0;
        w_size     = 2'b10;
        w_wdata    = lsu_wdata;
        w_wem      = '1;
        case (lsu_funct3[1:0])
            2'b00: begin
                w_size  = 2'b00;
                w_wdata = {(DATA_WIDTH/8){lsu_wdata[7:0]}};
                w_wem   = RAM_MASK_WIDTH'(1) << lsu_addr[1:0];
            end
            2'b01: begin
                w_size     = 2'b01;
                w_misalign = lsu_addr[0];
                w_wdata    = {(DATA_WIDTH/16){lsu_wdata[15:0]}};
                w_wem      = lsu_addr[1] ? RAM_MASK_WIDTH'(4'b1100) : RAM_MASK_WIDTH'(4'b0011);
            end
            default: begin
                w_misalign = (lsu_addr[1:0] != 2'b00);
            end
        endcase
        if (!lsu_we) begin
            w_wem = '0;
        end
    end

    always_comb begin
        w_push_entry = r_hold;
        if (!r_hold_valid) begin
            w_push_entry = '{bus: 1'b0, we: lsu_we, funct3: lsu_funct3, lane: lsu_addr[1:0]};
        end
    end

    always_comb begin
        w_lane_data = mem_rdata >> {w_head.lane, 3'b000};
        case (w_head.funct3)
            3'b000:  w_load_ext = {{(DATA_WIDTH-8){w_lane_data[7]}}, w_lane_data[7:0]};
            3'b001:  w_load_ext = {{(DATA_WIDTH-16){w_lane_data[15]}}, w_lane_data[15:0]};
            3'b100:  w_load_ext = {{(DATA_WIDTH-8){1'b0}}, w_lane_data[7:0]};
            3'b101:  w_load_ext = {{(DATA_WIDTH-16){1'b0}}, w_lane_data[15:0]};
            default: w_load_ext = w_lane_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_mem_we     <= 1'b0;
            r_mem_size   <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wem    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            if (w_accept && !w_misalign) begin
                r_hold_valid <= 1'b1;
                r_hold       <= '{bus: 1'b1, we: lsu_we, funct3: lsu_funct3, lane: lsu_addr[1:0]};
                r_mem_we     <= lsu_we;
                r_mem_size   <= w_size;
                r_mem_addr   <= {lsu_addr[BUS_WIDTH-1:2], 2'b00};
                r_mem_wdata  <= w_wdata;
                r_mem_wem    <= w_wem;
            end else if (r_hold_valid && mem_addr_ok) begin
                r_hold_valid <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
            r_rsp_valid <= w_pop || w_bypass;
            r_rsp_err   <= w_bypass || (w_pop && !w_head.bus);
            r_rsp_rdata <= (w_pop && w_head.bus && !w_head.we) ? w_load_ext : '0;
            if (w_stray) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
        end
    end

    assign mem_req   = r_hold_valid;
    assign mem_we    = r_mem_we;
    assign mem_size  = r_mem_size;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wem   = r_mem_wem;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign bus_err   = r_bus_err;
endmodule
